// File: rtl/toggle_pkg.sv
// Shared definitions for the two-phase toggle handshake channel. The matching
// transmitter imports the same defaults so both ends agree on the channel shape.
package toggle_pkg;

    localparam int unsigned DEF_DW          = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_W       = 8;

    // IDLE: no transfer outstanding. PEND: toggle seen, buffer full, waiting for space.
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

endpackage

// File: rtl/toggle_sync.sv
// Flop chain that brings a level signal into the local clock domain.
// Also used by the transmitter to synchronize ack_tgl.
module toggle_sync
    import toggle_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    generate
        if (SYNC_STAGES == 1) begin : g_single
            // Single-flop chain: sample the input directly.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_sync <= 1'b0;
                end else begin
                    r_sync <= i_d;
                end
            end
        end else begin : g_chain
            // Shift the input level through the chain, bit 0 nearest the input.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
                end
            end
        end
    endgenerate

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_rx.sv
// Receiving end of a two-phase toggle handshake. Each change of req_tgl is one
// transfer; the word is captured into a one-entry buffer feeding a valid/ready
// consumer and acknowledged by flipping ack_tgl. Backpressure withholds the ack.
module toggle_rx
    import toggle_pkg::*;
#(
    parameter int unsigned DW          = DEF_DW,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             CP,
    input  logic             rst,
    input  logic             req_tgl,
    input  logic [DW-1:0]    req_data,
    output logic             ack_tgl,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             ovf_err
);

    state_t            r_state;
    state_t            w_state_d;
    logic              w_s_last;
    logic              w_detect;
    logic              w_space;
    logic              w_accept;
    logic              w_violation;
    logic              r_req_prev;
    logic              r_req_last_d;
    logic              r_ack;
    logic              r_valid;
    logic [DW-1:0]     r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;

    toggle_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .i_clk (CP),
        .i_rst (rst),
        .i_d   (req_tgl),
        .o_q   (w_s_last)
    );

    assign w_detect = (w_s_last != r_req_prev);
    assign w_space  = !r_valid || out_ready;

    // A new sender toggle while the previous one is still unacknowledged.
    assign w_violation = (w_s_last != r_req_last_d) && (r_req_last_d != r_req_prev);

    // FSM state register.
    always_ff @(posedge CP) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state and accept decision. In PEND the transfer is delivered on space
    // even if a protocol violation has since cancelled the level difference.
    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_detect) begin
                    if (w_space) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (w_space) begin
                    w_accept  = 1'b1;
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Datapath: accept loads the buffer and flips the ack; a drain alone empties it.
    always_ff @(posedge CP) begin
        if (rst) begin
            r_req_prev   <= 1'b0;
            r_req_last_d <= 1'b0;
            r_ack        <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_req_last_d <= w_s_last;
            if (w_accept) begin
                r_data     <= req_data;
                r_valid    <= 1'b1;
                r_req_prev <= w_s_last;
                r_ack      <= ~r_ack;
                r_cnt      <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_violation) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign ack_tgl   = r_ack;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign evt_cnt   = r_cnt;
    assign ovf_err   = r_ovf;

endmodule

// File: tb/tb_toggle_rx.sv
// Directed bench for toggle_rx: a sender model drives toggles, a scoreboard
// queue holds the words expected at the valid/ready output.
module tb_toggle_rx;

    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = 8;

    logic             CP;
    logic             rst;
    logic             req_tgl;
    logic [DW-1:0]    req_data;
    logic             ack_tgl;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_ready;
    logic [CNT_W-1:0] evt_cnt;
    logic             ovf_err;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb_q[$];
    logic [CNT_W-1:0] exp_cnt;
    logic exp_ack;

    toggle_rx #(
        .DW          (DW),
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W)
    ) dut (
        .CP        (CP),
        .rst       (rst),
        .req_tgl   (req_tgl),
        .req_data  (req_data),
        .ack_tgl   (ack_tgl),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .evt_cnt   (evt_cnt),
        .ovf_err   (ovf_err)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change only 1 time unit after a rising edge.
    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit push);
        req_data = d;
        req_tgl  = ~req_tgl;
        if (push) sb_q.push_back(d);
    endtask

    task automatic wait_ack(input logic exp, input string tag);
        int n = 0;
        while (ack_tgl !== exp && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, ack_tgl}, {31'b0, exp});
    endtask

    // Output monitor: a word sampled with valid&&ready is consumed at the next edge.
    always @(negedge CP) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", {24'b0, out_data}, 32'hffff_ffff);
            end else begin
                chk("sb_data", {24'b0, out_data}, {24'b0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_tgl   = 1'b1;
        req_data  = 8'h5A;
        out_ready = 1'b1;
        exp_cnt   = '0;
        exp_ack   = 1'b0;
        sb_q.push_back(8'h5A);

        // Reset with req_tgl already high.
        tick();
        tick();
        chk("rst_ack", {31'b0, ack_tgl}, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", {24'b0, out_data}, 32'd0);
        chk("rst_cnt", {24'b0, evt_cnt}, 32'd0);
        chk("rst_ovf", {31'b0, ovf_err}, 32'd0);
        rst = 1'b0;
        exp_ack = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        wait_ack(exp_ack, "post_rst_ack");
        chk("post_rst_cnt", {24'b0, evt_cnt}, {24'b0, exp_cnt});
        tick();
        tick();

        // Single transfer latency: toggle sampled at edge k, valid after edge k+2.
        send(8'hA5, 1'b1);
        tick();
        tick();
        chk("lat_valid_early", {31'b0, out_valid}, 32'd0);
        tick();
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 8'd1;
        chk("lat_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_data", {24'b0, out_data}, 32'hA5);
        chk("lat_ack", {31'b0, ack_tgl}, {31'b0, exp_ack});
        tick();
        chk("lat_drain", {31'b0, out_valid}, 32'd0);

        // Backpressure: 0x11 held, 0x22 waits without ack.
        out_ready = 1'b0;
        send(8'h11, 1'b1);
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 8'd1;
        wait_ack(exp_ack, "bp_ack11");
        send(8'h22, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("bp_no_ack", {31'b0, ack_tgl}, {31'b0, exp_ack});
        chk("bp_held", {24'b0, out_data}, 32'h11);
        chk("bp_cnt_held", {24'b0, evt_cnt}, {24'b0, exp_cnt});
        out_ready = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 8'd1;
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_data22", {24'b0, out_data}, 32'h22);
        chk("bp_ack22", {31'b0, ack_tgl}, {31'b0, exp_ack});
        chk("bp_cnt", {24'b0, evt_cnt}, {24'b0, exp_cnt});
        tick();
        tick();

        // Drain and accept at the same edge.
        out_ready = 1'b0;
        send(8'h33, 1'b1);
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 8'd1;
        wait_ack(exp_ack, "sim_ack33");
        send(8'h44, 1'b1);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 8'd1;
        chk("sim_valid", {31'b0, out_valid}, 32'd1);
        chk("sim_data44", {24'b0, out_data}, 32'h44);
        chk("sim_ack44", {31'b0, ack_tgl}, {31'b0, exp_ack});
        tick();
        tick();

        // Protocol violation: second toggle before ack while buffer is full.
        out_ready = 1'b0;
        send(8'h55, 1'b1);
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 8'd1;
        wait_ack(exp_ack, "ovf_ack55");
        chk("ovf_clear", {31'b0, ovf_err}, 32'd0);
        send(8'h66, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        send(8'h77, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("ovf_set", {31'b0, ovf_err}, 32'd1);
        chk("ovf_no_ack", {31'b0, ack_tgl}, {31'b0, exp_ack});
        out_ready = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 8'd1;
        chk("ovf_deliver", {24'b0, out_data}, 32'h77);
        chk("ovf_ack", {31'b0, ack_tgl}, {31'b0, exp_ack});
        for (int i = 0; i < 5; i++) tick();
        chk("ovf_sticky", {31'b0, ovf_err}, 32'd1);
        chk("ovf_cnt", {24'b0, evt_cnt}, {24'b0, exp_cnt});

        // Reset clears the flag; req_tgl is high so one transfer follows.
        rst = 1'b1;
        req_data = 8'h88;
        sb_q.push_back(8'h88);
        tick();
        tick();
        chk("rst2_ovf", {31'b0, ovf_err}, 32'd0);
        chk("rst2_cnt", {24'b0, evt_cnt}, 32'd0);
        rst = 1'b0;
        exp_ack = 1'b1;
        exp_cnt = 8'd1;
        wait_ack(exp_ack, "rst2_ack");
        chk("rst2_cnt1", {24'b0, evt_cnt}, {24'b0, exp_cnt});
        tick();

        // Counter wrap: 255 more transfers reach 256 since reset.
        for (int i = 0; i < 255; i++) begin
            send(8'(i), 1'b1);
            exp_ack = ~exp_ack;
            exp_cnt = exp_cnt + 8'd1;
            wait_ack(exp_ack, "wrap_ack");
        end
        tick();
        tick();
        chk("wrap_cnt", {24'b0, evt_cnt}, {24'b0, exp_cnt});
        chk("wrap_zero", {24'b0, evt_cnt}, 32'd0);
        chk("wrap_parity", {31'b0, ack_tgl}, {31'b0, exp_cnt[0]});
        chk("wrap_ovf", {31'b0, ovf_err}, 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
